// File: rtl/doodle_motion.sv
// Doodle motion generator.
// Once per video frame, advances the doodle centre position and the climb
// counter according to the game state machine's one-hot state flags, the
// shared vertical speed and the left/right buttons. Also produces a one-clock
// pulse each time the state machine enters the Up state.
module doodle_motion #(
  parameter int unsigned START_X = 406,
  parameter int unsigned START_Y = 478,
  parameter int unsigned X_MIN   = 157,
  parameter int unsigned X_MAX   = 761,
  parameter int unsigned Y_MIN   = 35,
  parameter int unsigned Y_MAX   = 1023,
  parameter int unsigned H_SPEED = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        q_I,
  input  logic        q_Up,
  input  logic        q_Down,
  input  logic        q_Done,
  input  logic        is_in_middle,
  input  logic [3:0]  vert_speed,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [9:0]  up_count,
  output logic [15:0] object_x,
  output logic [15:0] object_y,
  output logic        jump_start
);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [9:0]  up_cnt_q, up_cnt_d;
  logic        jump_q, jump_d;
  logic        prev_up_q;

  logic        flags_legal;
  logic        upd;
  logic [10:0] up_sum;
  logic [16:0] y_up_floor;
  logic [16:0] y_down_sum;
  logic [16:0] x_left_floor;
  logic [16:0] x_right_sum;

  // Exactly one state flag high; anything else freezes the block.
  assign flags_legal = $onehot({q_I, q_Up, q_Down, q_Done});
  assign upd         = frame_tick & flags_legal;

  // Widened intermediates so the clamps never wrap.
  assign up_sum       = {1'b0, up_cnt_q} + 11'(vert_speed);
  assign y_up_floor   = 17'(Y_MIN) + 17'(vert_speed);
  assign y_down_sum   = {1'b0, y_q} + 17'(vert_speed);
  assign x_left_floor = 17'(X_MIN) + 17'(H_SPEED);
  assign x_right_sum  = {1'b0, x_q} + 17'(H_SPEED);

  // Next-state computation for position, climb counter and jump pulse.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    up_cnt_d = q_Up ? up_cnt_q : '0;
    jump_d   = q_Up & ~prev_up_q & flags_legal;

    if (upd) begin
      if (q_I) begin
        x_d = 16'(START_X);
        y_d = 16'(START_Y);
      end

      if (q_Up) begin
        up_cnt_d = up_sum[10] ? '1 : up_sum[9:0];
        if (!is_in_middle) begin
          if ({1'b0, y_q} < y_up_floor) begin
            y_d = 16'(Y_MIN);
          end else begin
            y_d = y_q - 16'(vert_speed);
          end
        end
      end

      if (q_Down) begin
        if (y_down_sum > 17'(Y_MAX)) begin
          y_d = 16'(Y_MAX);
        end else begin
          y_d = y_down_sum[15:0];
        end
      end

      if (q_Up || q_Down) begin
        if (btn_left && !btn_right) begin
          if ({1'b0, x_q} < x_left_floor) begin
            x_d = 16'(X_MIN);
          end else begin
            x_d = x_q - 16'(H_SPEED);
          end
        end else if (btn_right && !btn_left) begin
          if (x_right_sum > 17'(X_MAX)) begin
            x_d = 16'(X_MAX);
          end else begin
            x_d = x_right_sum[15:0];
          end
        end
      end
    end
  end

  // State registers with asynchronous reset to the idle position.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q       <= 16'(START_X);
      y_q       <= 16'(START_Y);
      up_cnt_q  <= '0;
      jump_q    <= 1'b0;
      prev_up_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      up_cnt_q  <= up_cnt_d;
      jump_q    <= jump_d;
      prev_up_q <= q_Up;
    end
  end

  assign object_x   = x_q;
  assign object_y   = y_q;
  assign up_count   = up_cnt_q;
  assign jump_start = jump_q;

endmodule

// File: tb/tb_doodle_motion.sv
// Self-checking bench for doodle_motion: a frame-level reference model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_doodle_motion;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        q_I = 1'b1, q_Up = 1'b0, q_Down = 1'b0, q_Done = 1'b0;
  logic        is_in_middle = 1'b0;
  logic [3:0]  vert_speed = 4'd0;
  logic        btn_left = 1'b0, btn_right = 1'b0;
  logic [9:0]  up_count;
  logic [15:0] object_x, object_y;
  logic        jump_start;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Reference model state (plain integers)
  int m_x = 406, m_y = 478, m_up = 0, m_js = 0, m_prev = 0;

  doodle_motion #(
    .START_X(406), .START_Y(478), .X_MIN(157), .X_MAX(761),
    .Y_MIN(35), .Y_MAX(1023), .H_SPEED(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
    .is_in_middle(is_in_middle), .vert_speed(vert_speed),
    .btn_left(btn_left), .btn_right(btn_right),
    .up_count(up_count), .object_x(object_x), .object_y(object_y),
    .jump_start(jump_start)
  );

  always #5 Clk = ~Clk;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: what one clock edge must do to the doodle.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_x = 406; m_y = 478; m_up = 0; m_js = 0; m_prev = 0;
    end else begin
      int nflags;
      int nx, ny, nup, njs;
      nflags = int'(q_I) + int'(q_Up) + int'(q_Down) + int'(q_Done);
      nx = m_x; ny = m_y;
      nup = q_Up ? m_up : 0;
      njs = (nflags == 1 && q_Up && m_prev == 0) ? 1 : 0;
      if (frame_tick && nflags == 1) begin
        if (q_I) begin
          nx = 406; ny = 478;
        end else if (q_Up) begin
          nup = imin(m_up + int'(vert_speed), 1023);
          if (!is_in_middle) ny = imax(m_y - int'(vert_speed), 35);
        end else if (q_Down) begin
          ny = imin(m_y + int'(vert_speed), 1023);
        end
        if ((q_Up || q_Down) && btn_left && !btn_right) nx = imax(m_x - 2, 157);
        if ((q_Up || q_Down) && btn_right && !btn_left) nx = imin(m_x + 2, 761);
      end
      m_x = nx; m_y = ny; m_up = nup; m_js = njs;
      m_prev = int'(q_Up);
    end
  end

  // Continuous comparison of DUT against the model, away from the active edge.
  always @(negedge Clk) begin
    if (check_en) begin
      check("model_x", int'(object_x), m_x);
      check("model_y", int'(object_y), m_y);
      check("model_up", int'(up_count), m_up);
      check("model_js", int'(jump_start), m_js);
    end
  end

  // One clock with frame_tick = t; returns 1 time unit after the edge.
  task automatic cyc(input bit t);
    frame_tick = t;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic flags(input bit i, input bit u, input bit d, input bit dn);
    q_I = i; q_Up = u; q_Down = d; q_Done = dn;
  endtask

  initial begin
    // Reset and idle
    #2 Reset = 1'b1;
    check_en = 1'b1;
    #1;
    check("rst_x", int'(object_x), 406);
    check("rst_y", int'(object_y), 478);
    check("rst_up", int'(up_count), 0);
    check("rst_js", int'(jump_start), 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    btn_left = 1'b1;
    ticks(10);
    btn_left = 1'b0;
    check("idle_x", int'(object_x), 406);
    check("idle_y", int'(object_y), 478);
    check("idle_up", int'(up_count), 0);

    // Jump arithmetic and jump_start pulse
    flags(0, 1, 0, 0); vert_speed = 4'd5; is_in_middle = 1'b0;
    cyc(1'b0);
    check("js_pulse", int'(jump_start), 1);
    cyc(1'b0);
    check("js_single", int'(jump_start), 0);
    ticks(4);
    check("jump_y", int'(object_y), 458);
    check("jump_up", int'(up_count), 20);

    // Climb to y=275, then scroll hold
    vert_speed = 4'd3;
    ticks(61);
    check("climb_y", int'(object_y), 275);
    check("climb_up", int'(up_count), 203);
    is_in_middle = 1'b1; vert_speed = 4'd4;
    ticks(3);
    check("scroll_y", int'(object_y), 275);
    check("scroll_up", int'(up_count), 215);

    // Top clamp from y=37
    is_in_middle = 1'b0; vert_speed = 4'd14;
    ticks(17);
    check("pre_top_y", int'(object_y), 37);
    vert_speed = 4'd5;
    ticks(1);
    check("top_clamp_y", int'(object_y), 35);
    check("top_clamp_up", int'(up_count), 458);

    // up_count saturation
    vert_speed = 4'd15;
    ticks(40);
    check("up_sat", int'(up_count), 1023);
    check("top_hold_y", int'(object_y), 35);

    // Left clamp from x=158
    btn_left = 1'b1;
    ticks(124);
    check("pre_left_x", int'(object_x), 158);
    ticks(3);
    check("left_clamp_x", int'(object_x), 157);
    btn_right = 1'b1;
    ticks(3);
    check("both_btn_x", int'(object_x), 157);
    btn_left = 1'b0;
    ticks(305);
    check("right_clamp_x", int'(object_x), 761);
    btn_right = 1'b0;

    // Down: up_count clears on the next clock regardless of tick
    flags(0, 0, 1, 0); vert_speed = 4'd7;
    cyc(1'b0);
    check("down_up_clr", int'(up_count), 0);
    is_in_middle = 1'b1;
    ticks(4);
    check("down_y", int'(object_y), 63);
    is_in_middle = 1'b0; vert_speed = 4'd15;
    ticks(66);
    check("down_sat_y", int'(object_y), 1023);
    btn_left = 1'b1;
    ticks(2);
    check("down_left_x", int'(object_x), 757);

    // Done: buttons and speed ignored
    flags(0, 0, 0, 1);
    ticks(5);
    check("done_x", int'(object_x), 757);
    check("done_y", int'(object_y), 1023);

    // Illegal flag combinations hold everything
    flags(0, 1, 1, 0); btn_left = 1'b0; btn_right = 1'b1; vert_speed = 4'd5;
    cyc(1'b1);
    check("illegal_js", int'(jump_start), 0);
    ticks(2);
    check("illegal_x", int'(object_x), 757);
    check("illegal_y", int'(object_y), 1023);
    check("illegal_up", int'(up_count), 0);
    flags(0, 0, 0, 0);
    ticks(3);
    check("noflag_x", int'(object_x), 757);
    btn_right = 1'b0;

    // Zero speed in Up, then normal climb, then reset mid-jump
    flags(0, 1, 0, 0); vert_speed = 4'd0;
    ticks(2);
    check("vs0_y", int'(object_y), 1023);
    check("vs0_up", int'(up_count), 0);
    vert_speed = 4'd5;
    ticks(2);
    check("rejump_y", int'(object_y), 1013);
    check("rejump_up", int'(up_count), 10);
    #2 Reset = 1'b1;
    #1;
    check("midrst_x", int'(object_x), 406);
    check("midrst_y", int'(object_y), 478);
    check("midrst_up", int'(up_count), 0);
    ticks(3);
    check("midrst_js", int'(jump_start), 0);
    Reset = 1'b0;
    cyc(1'b0);
    check("post_rst_js", int'(jump_start), 1);
    cyc(1'b0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
